// File: rtl/ahb_wr_master.sv
// AHB write master: turns paired AW/W FIFO entries into AHB SINGLE write
// transfers through a two-stage (address phase / data phase) pipeline that
// advances only when the slave signals hready.
module ahb_wr_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Write-request side
  input  logic              w_req,
  input  logic [ADDR_W-1:0] aw_addr0,
  input  logic [ADDR_W-1:0] aw_addr1,
  input  logic [2:0]        aw_size0,
  input  logic [2:0]        aw_size1,
  input  logic [DATA_W-1:0] w_data0,
  // FIFO handshakes
  output logic              aw_pop,
  output logic              w_pop,
  output logic              b_push,
  output logic [1:0]        b_resp,
  // Pipeline status
  output logic              w_phase1,
  output logic              w_phase2,
  // AHB master port
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp
);

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_NONSEQ = 2'b10
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;

  logic              phase1_q, phase1_d;
  logic              phase2_q, phase2_d;
  htrans_e           htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q,  haddr_d;
  logic [2:0]        hsize_q,  hsize_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;

  logic advance;

  // The whole pipeline moves forward together only on hready cycles.
  assign advance = hready;

  // Next-state: shift address phase into data phase and optionally start a new address phase.
  always_comb begin
    phase1_d = phase1_q;
    phase2_d = phase2_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    if (advance) begin
      // Data phase follows whatever was in address phase; the W FIFO head is
      // the beat that belongs to that address, popped in this same cycle.
      phase2_d = phase1_q;
      if (phase1_q) begin
        hwdata_d = w_data0;
      end
      if (w_req) begin
        // Entry 0 is still owned by the transfer leaving address phase when
        // phase1 is set, so the new transfer takes entry 1 in that case.
        phase1_d = 1'b1;
        htrans_d = HT_NONSEQ;
        haddr_d  = phase1_q ? aw_addr1 : aw_addr0;
        hsize_d  = phase1_q ? aw_size1 : aw_size0;
      end else begin
        phase1_d = 1'b0;
        htrans_d = HT_IDLE;
      end
    end
  end

  // Pipeline registers, cleared asynchronously so in-flight transfers are dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase1_q <= 1'b0;
      phase2_q <= 1'b0;
      htrans_q <= HT_IDLE;
      haddr_q  <= '0;
      hsize_q  <= '0;
      hwdata_q <= '0;
    end else begin
      phase1_q <= phase1_d;
      phase2_q <= phase2_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
    end
  end

  // FIFO strobes: pop when the address phase is accepted, push the response
  // when the data phase completes. Gated by rst so they stay quiet in reset.
  assign aw_pop = phase1_q & hready & ~rst;
  assign w_pop  = phase1_q & hready & ~rst;
  assign b_push = phase2_q & hready & ~rst;
  assign b_resp = (phase2_q & hready & hresp & ~rst) ? RESP_SLVERR : RESP_OKAY;

  assign w_phase1 = phase1_q;
  assign w_phase2 = phase2_q;
  assign htrans   = htrans_q;
  assign haddr    = haddr_q;
  assign hsize    = hsize_q;
  assign hwdata   = hwdata_q;
  // Writes only, single transfers only.
  assign hwrite   = 1'b1;
  assign hburst   = HBURST_SINGLE;

endmodule
